frame_buffer: RTL



---
 rtl/frame_buffer_if.sv | 20 ++
 rtl/frame_buffer.sv | 85 ++++++++
 2 files changed

// File: rtl/frame_buffer_if.sv
// frame_buffer_if: GPU write port plus VGA driver read port of the frame buffer.
interface frame_buffer_if #(
  parameter int WIDTH_ADDR = 11
);
  logic                  wr_en_in;
  logic [WIDTH_ADDR-1:0] wr_addr_in;
  logic [3:0]            wr_data_in;
  logic                  next_pixel_in;
  logic                  frame_reset_in;
  logic [3:0]            pixel_out;
  logic                  frame_end_out;
  modport master (
    output wr_en_in, wr_addr_in, wr_data_in, next_pixel_in, frame_reset_in,
    input  pixel_out, frame_end_out
  );
  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in, next_pixel_in, frame_reset_in,
    output pixel_out, frame_end_out
  );
endinterface

// File: rtl/frame_buffer.sv
// frame_buffer: 4-bit gray-scale buffer read in raster order with per-line vertical repeat.
module frame_buffer #(
  parameter int FB_WIDTH     = 40,
  parameter int FB_HEIGHT    = 30,
  parameter int WIDTH_REPEAT = 5,
  parameter int WIDTH_ADDR   = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH_REPEAT-1:0] line_repeat,
  frame_buffer_if.slave           bus
);
  localparam int DEPTH     = FB_WIDTH*FB_HEIGHT;
  localparam int WIDTH_COL = FB_WIDTH > 1 ? $clog2(FB_WIDTH) : 1;
  localparam logic [WIDTH_COL-1:0]  LAST_COL  = WIDTH_COL'(FB_WIDTH-1);
  localparam logic [WIDTH_ADDR-1:0] LAST_BASE = WIDTH_ADDR'((FB_HEIGHT-1)*FB_WIDTH);
  localparam logic [WIDTH_ADDR-1:0] LINE_STEP = WIDTH_ADDR'(FB_WIDTH);

  logic [3:0]              mem [DEPTH];
  logic [3:0]              pixel_q, pixel_d;
  logic                    frame_end_q, frame_end_d;
  logic                    next_pixel_q, next_pixel_d;
  logic [WIDTH_ADDR-1:0]   ptr_q, ptr_d, base_q, base_d;
  logic [WIDTH_COL-1:0]    col_q, col_d;
  logic [WIDTH_REPEAT-1:0] rep_q, rep_d;
  logic                    rise;

  // extra top bit keeps the range check correct when DEPTH is a power of two
  always_ff @(posedge clk)
    if (bus.wr_en_in && {1'b0, bus.wr_addr_in} < (WIDTH_ADDR+1)'(DEPTH))
      mem[bus.wr_addr_in] <= bus.wr_data_in;

  always_comb begin
    rise         = bus.next_pixel_in & ~next_pixel_q;
    next_pixel_d = bus.next_pixel_in;
    pixel_d      = mem[ptr_q];
    frame_end_d  = 1'b0;
    ptr_d        = ptr_q;
    base_d       = base_q;
    col_d        = col_q;
    rep_d        = rep_q;
    if (bus.frame_reset_in) begin
      ptr_d  = '0;
      base_d = '0;
      col_d  = '0;
      rep_d  = '0;
    end else if (rise && col_q != LAST_COL) begin
      col_d = col_q + WIDTH_COL'(1);
      ptr_d = ptr_q + WIDTH_ADDR'(1);
    end else if (rise) begin
      col_d = '0;
      if (rep_q != line_repeat) begin
        rep_d = rep_q + WIDTH_REPEAT'(1);
        ptr_d = base_q;
      end else begin
        rep_d       = '0;
        frame_end_d = base_q == LAST_BASE;
        base_d      = base_q == LAST_BASE ? '0 : base_q + LINE_STEP;
        ptr_d       = base_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pixel_q      <= '0;
      frame_end_q  <= 1'b0;
      next_pixel_q <= 1'b0;
      ptr_q        <= '0;
      base_q       <= '0;
      col_q        <= '0;
      rep_q        <= '0;
    end else begin
      pixel_q      <= pixel_d;
      frame_end_q  <= frame_end_d;
      next_pixel_q <= next_pixel_d;
      ptr_q        <= ptr_d;
      base_q       <= base_d;
      col_q        <= col_d;
      rep_q        <= rep_d;
    end

  assign bus.pixel_out     = pixel_q;
  assign bus.frame_end_out = frame_end_q;
endmodule
